// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_seq_pkg : operation codes, FSM encoding and iteration count
// Revision: 1.0
// ----------------------------------------------------------------------------
package muldiv_seq_pkg;

  localparam logic [1:0] C_MD_MULT  = 2'd0;
  localparam logic [1:0] C_MD_MULTU = 2'd1;
  localparam logic [1:0] C_MD_DIV   = 2'd2;
  localparam logic [1:0] C_MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned ITER_COUNT  = 32;
  localparam logic [5:0]  C_LAST_ITER = 6'(ITER_COUNT - 1);

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_seq_if : pipeline-side request/result bundle of the HI/LO unit
// Revision: 1.0
// ----------------------------------------------------------------------------
interface muldiv_seq_if;
  logic        in_start;
  logic [1:0]  in_md_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_hilo_read;
  logic        in_cancel;
  logic        out_busy;
  logic        out_stall;
  logic [31:0] out_hi_data;
  logic [31:0] out_lo_data;
  logic        out_hi_wena;
  logic        out_lo_wena;

  modport master (
    output in_start, in_md_op, in_a, in_b, in_hilo_read, in_cancel,
    input  out_busy, out_stall, out_hi_data, out_lo_data, out_hi_wena, out_lo_wena
  );

  modport slave (
    input  in_start, in_md_op, in_a, in_b, in_hilo_read, in_cancel,
    output out_busy, out_stall, out_hi_data, out_lo_data, out_hi_wena, out_lo_wena
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_step : one shift-add (multiply) or restoring-subtract (divide) step
// Revision: 1.0
// ----------------------------------------------------------------------------
module muldiv_step (
  input  logic        is_div_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] opnd_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [32:0] w_sum;
  logic [32:0] w_shift;
  logic [31:0] w_rem;
  logic        w_fits;

  always_comb begin
    w_sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : 33'd0);
    w_shift = {hi_i, lo_i[31]};
    w_fits  = (w_shift >= {1'b0, opnd_i});
    // Remainder is always below the divisor, so the low 32 bits are exact.
    w_rem   = w_shift[31:0] - opnd_i;
    if (is_div_i) begin
      hi_o = w_fits ? w_rem : w_shift[31:0];
      lo_o = {lo_i[30:0], w_fits};
    end else begin
      hi_o = w_sum[32:1];
      lo_o = {w_sum[0], lo_i[31:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// muldiv_seq : 32-iteration sequential MULT/MULTU/DIV/DIVU unit with HI/LO writeback
// Revision: 1.0
// ----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic         in_clk,
  input  logic         in_rst,
  muldiv_seq_if.slave  bus
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;

  logic        w_accept, w_in_mul, w_in_signed, w_signed;
  logic        w_neg_res, w_neg_rem, w_last, w_is_div, w_busy;
  logic [31:0] w_mag_a, w_mag_b, w_step_hi, w_step_lo;
  logic [63:0] w_prod;

  assign w_accept    = (state_q == ST_IDLE) & bus.in_start & ~bus.in_cancel;
  assign w_in_mul    = (bus.in_md_op == C_MD_MULT) | (bus.in_md_op == C_MD_MULTU);
  assign w_in_signed = (bus.in_md_op == C_MD_MULT) | (bus.in_md_op == C_MD_DIV);
  assign w_mag_a     = abs32(bus.in_a, w_in_signed);
  assign w_mag_b     = abs32(bus.in_b, w_in_signed);
  assign w_signed    = (op_q == C_MD_MULT) | (op_q == C_MD_DIV);
  assign w_neg_res   = w_signed & (a_q[31] ^ b_q[31]);
  assign w_neg_rem   = w_signed & a_q[31];
  assign w_last      = (cnt_q == C_LAST_ITER);
  assign w_is_div    = (state_q == ST_DIV);
  assign w_prod      = {w_step_hi, w_step_lo};

  muldiv_step u_step (
    .is_div_i (w_is_div),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (w_step_hi),
    .lo_o     (w_step_lo)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept) state_d = w_in_mul ? ST_MUL : ST_DIV;
      ST_MUL, ST_DIV: begin
        if (bus.in_cancel)  state_d = ST_IDLE;
        else if (w_last)    state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.out_busy    = w_busy;
    bus.out_stall   = w_busy & (bus.in_start | bus.in_hilo_read);
    bus.out_hi_wena = (state_q == ST_DONE) & ~bus.in_cancel;
    bus.out_lo_wena = (state_q == ST_DONE) & ~bus.in_cancel;
    bus.out_hi_data = res_hi_q;
    bus.out_lo_data = res_lo_q;
  end

  assign w_busy = (state_q != ST_IDLE);

  // Datapath: operands are held as magnitudes; signs are restored on the final step.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    if (w_accept) begin
      cnt_d  = 6'd0;
      op_d   = bus.in_md_op;
      a_d    = bus.in_a;
      b_d    = bus.in_b;
      hi_d   = 32'd0;
      lo_d   = w_in_mul ? w_mag_b : w_mag_a;
      opnd_d = w_in_mul ? w_mag_a : w_mag_b;
    end else if ((state_q == ST_MUL) || (state_q == ST_DIV)) begin
      cnt_d = cnt_q + 6'd1;
      hi_d  = w_step_hi;
      lo_d  = w_step_lo;
      if (w_last && !bus.in_cancel) begin
        if (state_q == ST_MUL) begin
          {res_hi_d, res_lo_d} = w_neg_res ? (~w_prod + 64'd1) : w_prod;
        end else if (b_q == 32'd0) begin
          res_hi_d = a_q;
          res_lo_d = 32'hFFFF_FFFF;
        end else if (w_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
          res_hi_d = 32'd0;
          res_lo_d = 32'h8000_0000;
        end else begin
          res_lo_d = w_neg_res ? (~w_step_lo + 32'd1) : w_step_lo;
          res_hi_d = w_neg_rem ? (~w_step_hi + 32'd1) : w_step_hi;
        end
      end
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt_q    <= 6'd0;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      opnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_muldiv_seq : scoreboard bench with random ops against an arithmetic model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  muldiv_seq_if bus ();

  muldiv_seq dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e_mon;
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          idle_at = 0;
  int          win_lo  = 1;
  int          win_hi  = 0;
  bit          hilo_force = 1'b0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;
  logic [1:0]  r_op;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  int          r_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain SystemVerilog arithmetic plus the architectural corner cases.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    int                sa, sb;
    longint            ps;
    longint unsigned   pu;
    sa = a;
    sb = b;
    case (op)
      C_MD_MULT: begin
        ps = longint'(sa) * longint'(sb);
        {hi, lo} = ps;
      end
      C_MD_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        {hi, lo} = pu;
      end
      C_MD_DIV: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin hi = 32'd0; lo = 32'h8000_0000; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge with inputs already set; checks busy/stall, then advances one cycle.
  task automatic tick();
    logic eb;
    bus.in_hilo_read = hilo_force ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    eb = (cyc >= win_lo) && (cyc <= win_hi);
    chk("busy", bus.out_busy, eb);
    chk("stall", bus.out_stall, eb & (bus.in_start | bus.in_hilo_read));
    @(negedge clk);
  endtask

  // Holds in_start until the unit is expected idle; returns at the first busy cycle.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                       input string tag, output int c);
    bus.in_start = 1'b1;
    bus.in_md_op = op;
    bus.in_a     = a;
    bus.in_b     = b;
    c = (cyc > idle_at) ? cyc : idle_at;
    if (push) begin
      exp_q.push_back('{ehi, elo, c + 33, tag});
      last_hi = ehi;
      last_lo = elo;
    end
    while (cyc < c) tick();
    tick();
    win_lo  = c + 1;
    win_hi  = c + 33;
    idle_at = c + 34;
  endtask

  task automatic drain();
    bus.in_start = 1'b0;
    while (cyc <= idle_at) tick();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_hi_wena || bus.out_lo_wena) begin
        chk("wena_pair", bus.out_hi_wena, bus.out_lo_wena);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wena: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e_mon = exp_q.pop_front();
          chk({e_mon.tag, "_hi"}, bus.out_hi_data, e_mon.hi);
          chk({e_mon.tag, "_lo"}, bus.out_lo_data, e_mon.lo);
          chk({e_mon.tag, "_cycle"}, cyc, e_mon.due);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
        checks++;
        errors++;
        $display("FAIL missing_wena %s: got none expected at cycle %0d", exp_q[0].tag, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_start     = 1'b1;
    bus.in_md_op     = C_MD_MULT;
    bus.in_a         = 32'd0;
    bus.in_b         = 32'd0;
    bus.in_hilo_read = 1'b1;
    bus.in_cancel    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy",  bus.out_busy, 1'b0);
    chk("rst_stall", bus.out_stall, 1'b0);
    chk("rst_hi",    bus.out_hi_data, 32'd0);
    chk("rst_lo",    bus.out_lo_data, 32'd0);
    chk("rst_wena",  {bus.out_hi_wena, bus.out_lo_wena}, 2'b00);
    @(negedge clk);
    bus.in_start = 1'b0;
    rst          = 1'b0;
    idle_at      = cyc;

    // Architectural vectors, back-to-back with a hazard read pending throughout.
    hilo_force = 1'b1;
    issue(C_MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", r_c);
    issue(C_MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", r_c);
    issue(C_MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", r_c);
    issue(C_MD_DIVU,  32'h0000_0064, 32'h0000_0000, 1'b1, 32'h0000_0064, 32'hFFFF_FFFF, "divu_zero", r_c);
    issue(C_MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000, "div_ovf", r_c);
    hilo_force = 1'b0;
    drain();

    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.in_start = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
      end
      r_op = 2'($urandom_range(0, 3));
      r_a  = rnd_opnd();
      r_b  = rnd_opnd();
      model(r_op, r_a, r_b, r_hi, r_lo);
      issue(r_op, r_a, r_b, 1'b1, r_hi, r_lo, "rand", r_c);
    end
    drain();

    // Flush at iteration 10: no writeback, results hold.
    issue(C_MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'd0, 32'd0, "cancel", r_c);
    bus.in_start = 1'b0;
    while (cyc < r_c + 11) tick();
    bus.in_cancel = 1'b1;
    tick();
    bus.in_cancel = 1'b0;
    win_hi  = r_c + 11;
    idle_at = r_c + 12;
    chk("cancel_hold_hi", bus.out_hi_data, last_hi);
    chk("cancel_hold_lo", bus.out_lo_data, last_lo);
    repeat (40) tick();

    // Flush beats a start request in IDLE.
    bus.in_start  = 1'b1;
    bus.in_cancel = 1'b1;
    tick();
    bus.in_start  = 1'b0;
    bus.in_cancel = 1'b0;
    tick();
    repeat (3) tick();

    // Reset at iteration 20: everything clears, no writeback follows.
    issue(C_MD_DIV, 32'hDEAD_BEEF, 32'h0000_0013, 1'b0, 32'd0, 32'd0, "reset", r_c);
    bus.in_start = 1'b0;
    while (cyc < r_c + 21) tick();
    bus.in_start     = 1'b1;
    bus.in_hilo_read = 1'b1;
    rst              = 1'b1;
    #1;
    chk("mid_rst_busy",  bus.out_busy, 1'b0);
    chk("mid_rst_stall", bus.out_stall, 1'b0);
    chk("mid_rst_hi",    bus.out_hi_data, 32'd0);
    chk("mid_rst_lo",    bus.out_lo_data, 32'd0);
    chk("mid_rst_wena",  {bus.out_hi_wena, bus.out_lo_wena}, 2'b00);
    repeat (2) @(negedge clk);
    bus.in_start = 1'b0;
    rst          = 1'b0;
    win_lo  = 1;
    win_hi  = 0;
    idle_at = cyc;
    #1;
    chk("post_rst_hi", bus.out_hi_data, 32'd0);
    chk("post_rst_lo", bus.out_lo_data, 32'd0);
    @(negedge clk);
    repeat (40) tick();

    r_a = rnd_opnd();
    r_b = rnd_opnd();
    model(C_MD_MULT, r_a, r_b, r_hi, r_lo);
    issue(C_MD_MULT, r_a, r_b, 1'b1, r_hi, r_lo, "after_rst", r_c);
    drain();

    for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL: reset in_rst, asynchronous, active-high.
REQ-002 SHALL: in_clk  input  1  pipeline clock, all state updates on rising edge.
REQ-003 SHALL: in_rst  input  1  asynchronous active-high reset.
REQ-004 SHALL: in_start  input  1  EXE stage holds a MULT/MULTU/DIV/DIVU instruction.
REQ-005 SHALL: in_md_op  input  2  operation: MULT, MULTU, DIV, DIVU (package codes).
REQ-006 SHALL: in_a  input  32  rs operand (multiplicand / dividend).
REQ-007 SHALL: in_b  input  32  rt operand (multiplier / divisor).
REQ-008 SHALL: in_hilo_read  input  1  ID stage holds MFHI or MFLO.
REQ-009 SHALL: in_cancel  input  1  exception flush; abandon in-flight operation.
REQ-010 SHALL: out_busy  output  1  operation in progress (states MUL, DIV, DONE).
REQ-011 SHALL: out_stall  output  1  combinational pipeline hold request.
REQ-012 SHALL: out_hi_data / out_lo_data  output  32 each  result for HI / LO.
REQ-013 SHALL: out_hi_wena / out_lo_wena  output  1 each  one-cycle HI/LO write strobes.

Function
REQ-014 SHALL: FSM states IDLE, MUL, DIV, DONE; 6-bit iteration counter.
REQ-015 SHALL: IDLE with in_start=1 and in_cancel=0 -> latch operands, counter=0, go MUL (MULT/MULTU) or DIV (DIV/DIVU).
REQ-016 SHALL: MUL/DIV perform one shift-add or restoring-subtract iteration per cycle for exactly 32 cycles, then go DONE.
REQ-017 SHALL: DONE lasts one cycle, drives results and asserts both wena strobes, then returns to IDLE; latency start-accept edge to DONE = 33 cycles.
REQ-018 SHALL: signed ops operate on magnitudes; product/quotient negated when operand signs differ; remainder takes dividend sign.
REQ-019 SHALL: LO = product[31:0] / quotient, HI = product[63:32] / remainder.
REQ-020 SHALL: divide by zero -> HI = dividend (unmodified in_a), LO = 0xFFFFFFFF, still 33-cycle latency.
REQ-021 SHALL: DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-022 SHALL: out_stall = out_busy & (in_start | in_hilo_read); zero in IDLE.
REQ-023 SHALL: in_start while busy is ignored (held by stall); re-accepted in first IDLE cycle.
REQ-024 SHALL: in_cancel in MUL/DIV/DONE -> IDLE next edge, no wena pulse; in_cancel overrides in_start in IDLE.
REQ-025 SHALL: wena strobes zero in every state except DONE; out_hi_data/out_lo_data hold last result otherwise.

Reset
REQ-026 SHALL: in_rst forces IDLE, counter 0, all operand/partial registers 0.
REQ-027 SHALL: all outputs 0 during and after reset until next DONE.
REQ-028 SHALL: reset mid-operation discards it; no wena pulse follows.

Structure
REQ-029 SHALL: package holds in_md_op codes, state encodings, iteration count constant (32).
REQ-030 SHALL: one sub-module muldiv_step: combinational single-iteration datapath (add/shift or trial-subtract/shift) instantiated by the FSM.
REQ-031 SHALL: sign fix-up and divide-by-zero/overflow overrides reside in muldiv_seq, applied on DIV->DONE transition.

Verification
REQ-032 SHALL: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 33 cycles later HI=0xFFFFFFFE, LO=0x00000001, wena high exactly one cycle.
REQ-033 SHALL: MULT 0xFFFFFFFD x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-034 SHALL: DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 0x64 / 0 -> HI=0x64, LO=0xFFFFFFFF.
REQ-035 SHALL: in_hilo_read held high from start -> out_stall=1 every cycle through DONE, 0 first IDLE cycle; back-to-back in_start accepted that cycle.
REQ-036 SHALL: in_cancel at iteration 10 -> IDLE next cycle, no wena; in_rst at iteration 20 -> all outputs 0, no wena afterwards.
